// File: rtl/shift_exec_if.sv
// Handshake and operand bundle between the shift-port issue queue, the shift
// execute stage and the writeback / flag-rename side.
//
// Handshake: a transfer occurs on a rising clk edge where valid && ready are
// both high. The sender holds valid and payload stable until the transfer
// happens, and never drops valid without one. Ready may depend
// combinationally on the downstream ready.
interface shift_exec_if #(
  parameter int WIDTH = 64,
  parameter int TAGW  = 9
);
  // issue side
  logic             in_vld;
  logic             in_rdy;
  logic             in_dir;
  logic             in_arith;
  logic             in_sz64;
  logic             in_rot;
  logic [WIDTH-1:0] in_val;
  logic [5:0]       in_cnt;
  logic [TAGW-1:0]  in_tag;
  // writeback side
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_res;
  logic [TAGW-1:0]  out_tag;
  logic             out_c;
  logic             out_z;
  logic             out_s;
  logic             out_fl_wr;

  // issue queue + writeback consumer
  modport master (
    output in_vld, in_dir, in_arith, in_sz64, in_rot, in_val, in_cnt, in_tag,
    input  in_rdy,
    input  out_vld, out_res, out_tag, out_c, out_z, out_s, out_fl_wr,
    output out_rdy
  );

  // execute stage
  modport slave (
    input  in_vld, in_dir, in_arith, in_sz64, in_rot, in_val, in_cnt, in_tag,
    output in_rdy,
    output out_vld, out_res, out_tag, out_c, out_z, out_s, out_fl_wr,
    input  out_rdy
  );
endinterface

// File: rtl/shift_exec_stage.sv
// Two-stage execute pipe around a 64-bit shifter for the integer shift port.
// S1 registers the accepted micro-op (count masked to op width); the shifter
// runs from S1 and S2 registers result, flags and tag for writeback.
// Optional macro SHF_ROTATE_EN: rotates run as two shifter passes under a
// small IDLE/PASS1/PASS2 FSM; without it in_rot is ignored.
module shift_exec_stage #(
  parameter int WIDTH = 64,
  parameter int TAGW  = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  shift_exec_if.slave  sif,
  output logic [1:0]   o_dbg_rot_state
);
  // S1 stage
  logic             r_s1_vld, r_s1_dir, r_s1_arith, r_s1_sz64;
  logic [5:0]       r_s1_cnt;
  logic [WIDTH-1:0] r_s1_val;
  logic [TAGW-1:0]  r_s1_tag;
  // S2 stage
  logic             r_out_vld, r_out_c, r_out_z, r_out_s, r_out_fl_wr;
  logic [WIDTH-1:0] r_out_res;
  logic [TAGW-1:0]  r_out_tag;
  // control
  logic       w_s2_adv, w_in_rdy, w_acc, w_s1_mv, w_fsm_idle, w_s1_hold;
  logic [5:0] w_cnt_eff;
  // shifter
  logic [3:0]              w_sz, w_bit_en;
  logic                    w_is64, w_sh_dir, w_sh_arith, w_fill;
  logic [5:0]              w_sh_cnt, w_sh_n;
  logic [WIDTH-1:0]        w_src, w_sh_raw, w_sh_res;
  logic signed [WIDTH+1:0] w_r_tmp, w_r_sh;
  logic [WIDTH:0]          w_l_sh;
  logic                    w_cout_r, w_sh_cout;
  logic [3:2]              w_cout_l;
  // result assembly
  logic [WIDTH-1:0] w_res_pre, w_res_fin;
  logic             w_c_pre, w_cnt_zero;
  logic             w_unused;

  assign w_s2_adv  = ~r_out_vld | sif.out_rdy;
  assign w_in_rdy  = (~r_s1_vld | w_s2_adv) & w_fsm_idle;
  assign w_acc     = sif.in_vld & w_in_rdy;
  assign w_s1_mv   = r_s1_vld & w_s2_adv & ~w_s1_hold;
  assign w_cnt_eff = sif.in_sz64 ? sif.in_cnt : {1'b0, sif.in_cnt[4:0]};

  // S1: capture accepted op, drain when it moves to S2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_dir <= 1'b0;
      r_s1_arith <= 1'b0;
      r_s1_sz64 <= 1'b0;
      r_s1_cnt <= '0;
      r_s1_val <= '0;
      r_s1_tag <= '0;
    end else if (flush) begin
      r_s1_vld <= 1'b0;
    end else if (w_acc) begin
      r_s1_vld   <= 1'b1;
      r_s1_dir   <= sif.in_dir;
      r_s1_arith <= sif.in_arith;
      r_s1_sz64  <= sif.in_sz64;
      r_s1_cnt   <= w_cnt_eff;
      r_s1_val   <= sif.in_val;
      r_s1_tag   <= sif.in_tag;
    end else if (w_s1_mv) begin
      r_s1_vld <= 1'b0;
    end
  end

  // shifter control: sz is one-hot op size, bit_en gates count bits 3..5
  assign w_sz     = r_s1_sz64 ? 4'b1000 : 4'b0100;
  assign w_bit_en = r_s1_sz64 ? 4'b0111 : 4'b0011;
  assign w_is64   = w_sz[3];
  assign w_sh_n   = w_sh_cnt & {w_bit_en[2:0], 3'b111};

  // 32-bit right shifts see a sign/zero-extended low word
  assign w_src   = w_is64 ? r_s1_val
                          : {{32{w_sh_arith & r_s1_val[31]}}, r_s1_val[31:0]};
  assign w_fill  = w_sh_arith & w_src[63];
  // guard bit below LSB catches the right-shift carry
  assign w_r_tmp = {w_fill, w_src, 1'b0};
  assign w_r_sh  = w_r_tmp >>> w_sh_n;
  assign w_l_sh  = {1'b0, r_s1_val} << w_sh_n;
  assign w_cout_r    = w_r_sh[0];
  assign w_cout_l[3] = w_l_sh[64];
  assign w_cout_l[2] = w_l_sh[32];

  // shifter datapath and carry selection
  always_comb begin
    w_sh_raw = w_sh_dir ? w_r_sh[64:1] : w_l_sh[63:0];
    w_sh_res = {w_sh_raw[63:32] & {32{w_is64}}, w_sh_raw[31:0]};
    if (w_sh_dir) w_sh_cout = w_cout_r;
    else          w_sh_cout = w_is64 ? w_cout_l[3] : w_cout_l[2];
  end

`ifdef SHF_ROTATE_EN
  typedef enum logic [1:0] {
    ROT_IDLE  = 2'd0,
    ROT_PASS1 = 2'd1,
    ROT_PASS2 = 2'd2
  } rot_state_e;

  rot_state_e       r_rot_state, w_rot_next;
  logic             r_s1_rot, w_rot_go, w_pass2;
  logic [WIDTH-1:0] r_rot_a;

  // rotate by zero takes the single-pass path and returns the operand
  assign w_rot_go   = w_acc & sif.in_rot & (w_cnt_eff != 6'd0);
  assign w_fsm_idle = (r_rot_state == ROT_IDLE);
  assign w_s1_hold  = (r_rot_state == ROT_PASS1);
  assign w_pass2    = (r_rot_state == ROT_PASS2);

  // rotate FSM next state
  always_comb begin
    w_rot_next = r_rot_state;
    case (r_rot_state)
      ROT_IDLE:  if (w_rot_go) w_rot_next = ROT_PASS1;
      ROT_PASS1: w_rot_next = ROT_PASS2;
      ROT_PASS2: if (w_s2_adv) w_rot_next = ROT_IDLE;
      default:   w_rot_next = ROT_IDLE;
    endcase
  end

  // rotate FSM state, rotate flag and pass-1 partial
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rot_state <= ROT_IDLE;
      r_s1_rot    <= 1'b0;
      r_rot_a     <= '0;
    end else begin
      r_rot_state <= flush ? ROT_IDLE : w_rot_next;
      if (w_acc) r_s1_rot <= sif.in_rot;
      if (r_rot_state == ROT_PASS1) r_rot_a <= w_sh_res;
    end
  end

  // pass 2 shifts the other way by (opwidth - n); 6-bit wrap gives 64 - n
  assign w_sh_dir   = w_pass2 ? ~r_s1_dir : r_s1_dir;
  assign w_sh_arith = r_s1_arith & ~r_s1_rot;
  assign w_sh_cnt   = w_pass2 ? ((r_s1_sz64 ? 6'd0 : 6'd32) - r_s1_cnt) : r_s1_cnt;
  assign w_res_pre  = w_pass2 ? (r_rot_a | w_sh_res) : w_sh_res;
  // rol carry is result bit 0, ror carry is result MSB
  assign w_c_pre    = w_pass2 ? (r_s1_dir ? (r_s1_sz64 ? w_res_pre[63] : w_res_pre[31])
                                          : w_res_pre[0])
                              : w_sh_cout;
  assign o_dbg_rot_state = r_rot_state;
  assign w_unused = ^{w_sz[2:0], w_bit_en[3], w_r_sh[65]};
`else
  assign w_fsm_idle = 1'b1;
  assign w_s1_hold  = 1'b0;
  assign w_sh_dir   = r_s1_dir;
  assign w_sh_arith = r_s1_arith;
  assign w_sh_cnt   = r_s1_cnt;
  assign w_res_pre  = w_sh_res;
  assign w_c_pre    = w_sh_cout;
  assign o_dbg_rot_state = 2'b00;
  assign w_unused = ^{w_sz[2:0], w_bit_en[3], w_r_sh[65], sif.in_rot};
`endif

  // zero count passes the operand through and suppresses the flag write
  assign w_cnt_zero = (r_s1_cnt == 6'd0);
  assign w_res_fin  = w_cnt_zero ? (r_s1_sz64 ? r_s1_val : {32'h0, r_s1_val[31:0]})
                                 : w_res_pre;

  // S2: load from S1 on advance, hold while stalled, drain on dequeue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld   <= 1'b0;
      r_out_res   <= '0;
      r_out_tag   <= '0;
      r_out_c     <= 1'b0;
      r_out_z     <= 1'b0;
      r_out_s     <= 1'b0;
      r_out_fl_wr <= 1'b0;
    end else if (flush) begin
      r_out_vld <= 1'b0;
    end else if (w_s1_mv) begin
      r_out_vld   <= 1'b1;
      r_out_res   <= w_res_fin;
      r_out_tag   <= r_s1_tag;
      r_out_c     <= w_cnt_zero ? 1'b0 : w_c_pre;
      r_out_z     <= (w_res_fin == '0);
      r_out_s     <= r_s1_sz64 ? w_res_fin[63] : w_res_fin[31];
      r_out_fl_wr <= ~w_cnt_zero;
    end else if (sif.out_rdy) begin
      r_out_vld <= 1'b0;
    end
  end

  assign sif.in_rdy    = w_in_rdy;
  assign sif.out_vld   = r_out_vld;
  assign sif.out_res   = r_out_res;
  assign sif.out_tag   = r_out_tag;
  assign sif.out_c     = r_out_c;
  assign sif.out_z     = r_out_z;
  assign sif.out_s     = r_out_s;
  assign sif.out_fl_wr = r_out_fl_wr;
endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage: single-op vectors with hand-computed
// results and latency, an 8-op stream under writeback backpressure, a flush
// with both stages full, and rotate vectors when SHF_ROTATE_EN is defined.
module tb_shift_exec_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] dbg_state;
  int         n_vec = 0;
  int         n_err = 0;
  logic [72:0] exp_q[$];

  shift_exec_if #(.WIDTH(64), .TAGW(9)) sif ();

  shift_exec_stage #(.WIDTH(64), .TAGW(9)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .sif             (sif),
    .o_dbg_rot_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, bench did not finish");
    $fatal(1);
  end

  // checker
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sif.in_vld = 1'b0; sif.in_dir = 1'b0; sif.in_arith = 1'b0;
    sif.in_sz64 = 1'b0; sif.in_rot = 1'b0; sif.in_val = '0;
    sif.in_cnt = '0; sif.in_tag = '0; sif.out_rdy = 1'b1; flush = 1'b0;
  endtask

  task automatic drive_op(input logic dir, input logic arith, input logic sz64,
                          input logic rot, input logic [63:0] val,
                          input logic [5:0] cnt, input logic [8:0] tag);
    sif.in_vld = 1'b1; sif.in_dir = dir; sif.in_arith = arith;
    sif.in_sz64 = sz64; sif.in_rot = rot; sif.in_val = val;
    sif.in_cnt = cnt; sif.in_tag = tag;
  endtask

  // one op through an empty pipe; checks latency, in_rdy-low cycles and outputs
  task automatic run_single(input string name, input logic dir, input logic arith,
                            input logic sz64, input logic rot, input logic [63:0] val,
                            input logic [5:0] cnt, input logic [8:0] tag,
                            input logic [63:0] e_res, input logic e_c, input logic e_z,
                            input logic e_s, input logic e_fl, input int e_lat,
                            input int e_rdy_lo);
    int lat;
    int rdy_lo;
    tick();
    sif.out_rdy = 1'b1;
    drive_op(dir, arith, sz64, rot, val, cnt, tag);
    @(negedge clk);
    check({name, "/in_rdy"}, sif.in_rdy, 1);
    tick();
    sif.in_vld = 1'b0;
    lat = 0;
    rdy_lo = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (!sif.in_rdy && !sif.out_vld) rdy_lo++;
      if (sif.out_vld) break;
    end
    check({name, "/latency"}, lat, e_lat);
    check({name, "/rdy_low"}, rdy_lo, e_rdy_lo);
    check({name, "/res"}, sif.out_res, e_res);
    check({name, "/tag"}, sif.out_tag, tag);
    check({name, "/c"}, sif.out_c, e_c);
    check({name, "/z"}, sif.out_z, e_z);
    check({name, "/s"}, sif.out_s, e_s);
    check({name, "/fl_wr"}, sif.out_fl_wr, e_fl);
  endtask

  logic [63:0] st_exp [8] = '{64'h2, 64'h4, 64'h8, 64'h10,
                              64'h20, 64'h40, 64'h80, 64'h100};

  // main sequence
  initial begin
    int sent, got, cyc, seen;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset/out_vld", sif.out_vld, 0);
    check("reset/out_res", sif.out_res, 0);
    check("reset/out_tag", sif.out_tag, 0);
    check("reset/out_c", sif.out_c, 0);
    check("reset/out_z", sif.out_z, 0);
    check("reset/out_s", sif.out_s, 0);
    check("reset/out_fl_wr", sif.out_fl_wr, 0);
    check("reset/in_rdy", sif.in_rdy, 1);
    check("reset/fsm", dbg_state, 0);

    //          name        dir ar sz rot val                     cnt    tag     res                    c  z  s  fl lat lo
    run_single("shl64_1",   0, 0, 1, 0, 64'h8000_0000_0000_0001, 6'd1,  9'h011, 64'h2,                 1, 0, 0, 1, 2, 0);
    run_single("sar32_4",   1, 1, 0, 0, 64'hFFFF_FFFF_8000_0000, 6'd4,  9'h022, 64'h0000_0000_F800_0000, 0, 0, 1, 1, 2, 0);
    run_single("shr32_36",  1, 0, 0, 0, 64'hFFFF_FFFF_8000_0000, 6'd36, 9'h033, 64'h0000_0000_0800_0000, 0, 0, 0, 1, 2, 0);
    run_single("cnt0_64",   0, 0, 1, 0, 64'h1234,                6'd0,  9'h044, 64'h1234,              0, 0, 0, 0, 2, 0);
    run_single("shr64_z",   1, 0, 1, 0, 64'h1,                   6'd1,  9'h055, 64'h0,                 1, 1, 0, 1, 2, 0);
    run_single("shl32_c",   0, 0, 0, 0, 64'h0000_0001_C000_0000, 6'd2,  9'h066, 64'h0,                 1, 1, 0, 1, 2, 0);
    run_single("sar64_63",  1, 1, 1, 0, 64'h8000_0000_0000_0000, 6'd63, 9'h077, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 1, 2, 0);
    run_single("cnt32_32",  0, 0, 0, 0, 64'hABCD_0000_8000_0000, 6'd32, 9'h088, 64'h0000_0000_8000_0000, 0, 0, 1, 0, 2, 0);
    run_single("shl64_63",  0, 0, 1, 0, 64'h3,                   6'd63, 9'h099, 64'h8000_0000_0000_0000, 1, 0, 1, 1, 2, 0);
`ifdef SHF_ROTATE_EN
    run_single("ror64_1",   1, 0, 1, 1, 64'h1,                   6'd1,  9'h0A1, 64'h8000_0000_0000_0000, 1, 0, 1, 1, 3, 2);
    run_single("rol32_4",   0, 1, 0, 1, 64'h8000_0001,           6'd4,  9'h0A2, 64'h18,                0, 0, 0, 1, 3, 2);
    run_single("rot_n0",    0, 0, 1, 1, 64'h1234_5678,           6'd0,  9'h0A3, 64'h1234_5678,         0, 0, 0, 0, 2, 0);
`else
    run_single("rot_ign",   1, 0, 1, 1, 64'h1,                   6'd1,  9'h0A1, 64'h0,                 1, 1, 0, 1, 2, 0);
`endif

    // stream of 8 shl64 by k+1 of 1, writeback ready pattern 1,0,0,1
    for (int k = 0; k < 8; k++) exp_q.push_back({9'h040 + 9'(k), st_exp[k]});
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 80) begin
      tick();
      sif.out_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (sent < 8) drive_op(0, 0, 1, 0, 64'h1, 6'(sent + 1), 9'h040 + 9'(sent));
      else sif.in_vld = 1'b0;
      @(negedge clk);
      if (sif.out_vld) begin
        if (exp_q.size() == 0) begin
          check("stream/extra", 1, 0);
        end else begin
          check("stream/tag", sif.out_tag, exp_q[0][72:64]);
          check("stream/res", sif.out_res, exp_q[0][63:0]);
          if (sif.out_rdy) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (sif.in_vld && sif.in_rdy) sent++;
      cyc++;
    end
    check("stream/sent", sent, 8);
    check("stream/got", got, 8);
    check("stream/left", exp_q.size(), 0);

    // flush with S1 and S2 full and a new accept in the same cycle
    tick();
    sif.out_rdy = 1'b0;
    drive_op(0, 0, 1, 0, 64'h5, 6'd1, 9'h1A1);
    @(negedge clk);
    check("flush/acc_a", sif.in_rdy, 1);
    tick();
    drive_op(0, 0, 1, 0, 64'h6, 6'd1, 9'h0B2);
    @(negedge clk);
    check("flush/acc_b", sif.in_rdy, 1);
    tick();
    sif.out_rdy = 1'b1;
    flush = 1'b1;
    drive_op(0, 0, 1, 0, 64'h7, 6'd1, 9'h0C3);
    @(negedge clk);
    check("flush/s2_full", sif.out_vld, 1);
    check("flush/s2_tag", sif.out_tag, 9'h1A1);
    check("flush/acc_c", sif.in_rdy, 1);
    tick();
    flush = 1'b0;
    sif.in_vld = 1'b0;
    @(negedge clk);
    check("flush/out_vld", sif.out_vld, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sif.out_vld) seen++;
    end
    check("flush/no_results", seen, 0);
    check("flush/in_rdy", sif.in_rdy, 1);

    // pipe still works after the flush
    run_single("post_flush", 0, 0, 1, 0, 64'h1, 6'd4, 9'h0D4, 64'h10, 0, 0, 0, 1, 2, 0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Pipelined execute stage that wraps the combinational 64-bit shifter (shlr) for the integer shift port.
- Accepts issued shift micro-ops through a valid/ready handshake and registers operands (S1). Drives the shifter, then registers the result, flags and tag (S2) for writeback.
- Sits between the shift-port issue queue and the result bus / flag rename.

Parameters:
- WIDTH, 64, datapath width; only 64 is supported.
- TAGW, 9, width of the destination register tag.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_vld  in  1  issue offers a micro-op.
- in_rdy  out  1  stage accepts; a transfer occurs when in_vld && in_rdy.
- in_dir  in  1  1 = right shift, 0 = left shift.
- in_arith  in  1  arithmetic right shift (sign fill).
- in_sz64  in  1  1 = 64-bit op, 0 = 32-bit op.
- in_rot  in  1  rotate op; honoured only with SHF_ROTATE_EN.
- in_val  in  WIDTH  source operand.
- in_cnt  in  6  shift count.
- in_tag  in  TAGW  destination tag.
- flush  in  1  kill all in-flight ops.
- out_vld  out  1  result valid.
- out_rdy  in  1  writeback accepts.
- out_res  out  WIDTH  result; upper 32 bits are 0 for 32-bit ops.
- out_tag  out  TAGW  tag of the result.
- out_c  out  1  carry (last bit shifted out).
- out_z  out  1  result == 0, evaluated over the op width.
- out_s  out  1  result sign: bit 63, or bit 31 for 32-bit ops.
- out_fl_wr  out  1  flags are written; 0 when the effective count is 0.

Behaviour:
- Reset: out_vld=0, out_res=0, out_tag=0, out_c/z/s=0, out_fl_wr=0, in_rdy=1, S1 empty, rotate FSM in IDLE.
- Count masking: effective count = in_cnt[5:0] for 64-bit ops and {1'b0, in_cnt[4:0]} for 32-bit ops. Masking is applied when S1 captures.
- S1 capture: on an accepted transfer, register dir, arith, sz, count, operand and tag.
- S1 to shifter mapping:
  - sz = 4'b1000 for 64-bit ops, 4'b0100 for 32-bit ops.
  - bit_en = 4'b0111 for 64-bit ops, 4'b0011 for 32-bit ops.
- Carry selection:
  - right shift: coutR.
  - 64-bit left shift: coutL[3].
  - 32-bit left shift: coutL[2].
- Effective count 0: out_res = operand (upper half zeroed for 32-bit ops), out_fl_wr=0, out_c=0.
- Latency: result is visible in S2 exactly 2 cycles after acceptance, given no backpressure. Throughput is 1 op/cycle.
- Handshake:
  - S2 advance = ~out_vld | out_rdy.
  - S1 moves to S2 when S1 is valid and S2 advances.
  - in_rdy = (~s1_vld | S2 advance) && rot FSM in IDLE. in_rdy is combinational from out_rdy; no skid buffer.
  - out_* are held stable while out_vld && ~out_rdy.
- Flush:
  - Clears s1_vld and out_vld at the next edge and returns the FSM to IDLE.
  - A transfer accepted in the same cycle as flush is discarded.
  - rst has priority over flush.
- Simultaneous events: S2 dequeue, S1 to S2 move and a new accept may all occur in one cycle without loss.

Optional Feature:
- Macro: SHF_ROTATE_EN.
- With the macro, an op with in_rot=1 is handled by a two-pass FSM (states IDLE, PASS1, PASS2) using the same shifter:
  - PASS1: shift in the given direction by n, logical fill; latch partial A.
  - PASS2: shift in the opposite direction by (opwidth − n); result = A | B.
  - n == 0: a single pass returning the operand.
  - in_rdy=0 from the rotate's acceptance until the PASS2 result moves into S2. Latency is 3 cycles.
  - Carry: rol gives result bit 0; ror gives result MSB (bit 63/31).
  - in_arith is ignored for rotates.
- Without the macro: in_rot is ignored (the op runs as a plain shift), there is no FSM, and in_rdy has no FSM term.

Test Plan:
- 64-bit shl of 0x8000_0000_0000_0001 by 1 -> out_res=0x0000_0000_0000_0002, out_c=1, out_z=0, out_s=0, out_fl_wr=1; out_vld 2 cycles after accept.
- 32-bit sar of 0xFFFF_FFFF_8000_0000 by 4 -> out_res=0x0000_0000_F800_0000, out_s=1, out_c=0; 32-bit shr by 36 treated as a count of 4.
- Count 0 on 0x1234 -> out_res=0x1234, out_fl_wr=0.
- Back-to-back stream of 8 ops with out_rdy toggling 1,0,0,1 -> all 8 results in order, no drops or duplicates, outputs stable while stalled.
- Flush asserted with S1 and S2 both full plus a new accept in the same cycle -> out_vld=0 next cycle, no result for any of the 3 tags.
- (SHF_ROTATE_EN) 64-bit ror of 0x1 by 1 -> out_res=0x8000_0000_0000_0000, out_c=1, in_rdy low 2 cycles; 32-bit rol of 0x8000_0001 by 4 -> 0x0000_0018.
